// File: rtl/fft_cap_pkg.sv
// Shared defaults and state encoding for the FFT magnitude capture block.
package fft_cap_pkg;

    localparam int DEF_FFT_LEN = 512;
    localparam int DEF_N_BINS  = 256;
    localparam int DEF_DW      = 16;
    localparam int DEF_MW      = 16;
    localparam int DEF_AW      = 8;

    localparam logic [4:0] ENC_IDLE    = 5'b00001;
    localparam logic [4:0] ENC_SYNC    = 5'b00010;
    localparam logic [4:0] ENC_CAPTURE = 5'b00100;
    localparam logic [4:0] ENC_FLUSH   = 5'b01000;
    localparam logic [4:0] ENC_DONE    = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE    = ENC_IDLE,
        ST_SYNC    = ENC_SYNC,
        ST_CAPTURE = ENC_CAPTURE,
        ST_FLUSH   = ENC_FLUSH,
        ST_DONE    = ENC_DONE
    } cap_state_t;

endpackage

// File: rtl/mag_approx.sv
// Two-stage magnitude approximation: |re|,|im| then max + min/2, saturated.
// Valid and RAM address ride alongside the data so the write lines up with the sample.
module mag_approx #(
    parameter int DW = 16,
    parameter int MW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [MW-1:0] out_mag
);

    localparam int SW = (DW + 1 > MW) ? DW + 1 : MW;
    localparam logic [SW-1:0] SAT = SW'({MW{1'b1}});

    logic [DW-1:0] abs_re, abs_im;
    logic [DW-1:0] s1_a, s1_b;
    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] mx, mn;
    logic [SW-1:0] sum;

    // Negating the most negative value wraps to 2^(DW-1), which is exact as unsigned.
    always_comb begin
        abs_re = in_re[DW-1] ? (~in_re + DW'(1)) : in_re;
        abs_im = in_im[DW-1] ? (~in_im + DW'(1)) : in_im;
        mx     = (s1_a > s1_b) ? s1_a : s1_b;
        mn     = (s1_a > s1_b) ? s1_b : s1_a;
        sum    = SW'(mx) + SW'(mn >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_mag   <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_addr   <= in_addr;
            s1_a      <= abs_re;
            s1_b      <= abs_im;
            out_valid <= s1_valid;
            out_addr  <= s1_addr;
            out_mag   <= (sum > SAT) ? {MW{1'b1}} : MW'(sum);
        end
    end

endmodule

// File: rtl/fft_mag_capture.sv
// Captures one FFT frame as per-bin magnitudes into a 2^AW x MW RAM for the detector.
// state   | meaning
// IDLE    | waiting for first start edge
// SYNC    | waiting for a tlast beat to align to a frame boundary
// CAPTURE | counting beats k, writing bins k < N_BINS
// FLUSH   | two cycles to drain the magnitude pipe
// DONE    | RAM holds a complete frame, done=1
module fft_mag_capture
    import fft_cap_pkg::*;
#(
    parameter int FFT_LEN = DEF_FFT_LEN,
    parameter int N_BINS  = DEF_N_BINS,
    parameter int DW      = DEF_DW,
    parameter int MW      = DEF_MW,
    parameter int AW      = DEF_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] s_tdata,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    output logic            s_tready,
    input  logic [AW-1:0]   rd_addr,
    output logic [MW-1:0]   rd_data,
    output logic            done,
    output logic            busy,
    output logic            frame_err
);

    localparam int KW = $clog2(FFT_LEN);

    cap_state_t    state;
    logic [KW-1:0] k;
    logic          flush_cnt;
    logic          start_d0, start_d1;
    logic          start_edge;
    logic          k_last, k_in_range, push;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [MW-1:0] wr_data;
    logic [MW-1:0] mem [0:(2**AW)-1];

    assign start_edge = start_d0 & ~start_d1;
    assign k_last     = (k == KW'(FFT_LEN - 1));
    assign k_in_range = ({1'b0, k} < (KW+1)'(N_BINS));
    assign push       = (state == ST_CAPTURE) && s_tvalid && k_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_d0 <= 1'b0;
            start_d1 <= 1'b0;
        end else begin
            start_d0 <= start;
            start_d1 <= start_d0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            k         <= '0;
            flush_cnt <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            s_tready  <= 1'b0;
        end else begin
            s_tready <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state     <= ST_SYNC;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (s_tvalid && s_tlast) begin
                        state <= ST_CAPTURE;
                        k     <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (s_tvalid) begin
                        k <= k + KW'(1);
                        if (k_last && s_tlast) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= 1'b0;
                        end else if (k_last || s_tlast) begin
                            state     <= ST_SYNC;
                            frame_err <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (start_edge) begin
                        state     <= ST_SYNC;
                        done      <= 1'b0;
                        frame_err <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mag_approx #(
        .DW(DW),
        .MW(MW),
        .AW(AW)
    ) u_mag (
        .clk      (clk),
        .rst      (rst),
        .in_valid (push),
        .in_re    (s_tdata[DW-1:0]),
        .in_im    (s_tdata[2*DW-1:DW]),
        .in_addr  (k[AW-1:0]),
        .out_valid(wr_en),
        .out_addr (wr_addr),
        .out_mag  (wr_data)
    );

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Non-blocking read of the same array gives read-first on address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_fft_mag_capture.sv
// Scoreboard bench for fft_mag_capture: expected bin magnitudes queued at drive time, checked on readback.
module tb_fft_mag_capture;

    localparam int FFT_LEN = 512;
    localparam int N_BINS  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [7:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        done, busy, frame_err;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    fft_mag_capture dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .done     (done),
        .busy     (busy),
        .frame_err(frame_err)
    );

    function automatic int mag_model(input int re, input int im);
        int a, b, mx, mn, m;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        m  = mx + mn / 2;
        if (m > 65535) m = 65535;
        return m;
    endfunction

    task automatic drive_beat(input int re, input int im, input bit last);
        s_tdata  = {16'(im), 16'(re)};
        s_tvalid = 1'b1;
        s_tlast  = last;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // mode 0: 3000/-4000, 1: re=k, 2: abs edges + random, 3: re=100, 4: re=7
    task automatic send_frame(input int mode, input bit capture, input int last_beat);
        int re, im;
        for (int k = 0; k <= last_beat; k++) begin
            case (mode)
                0: begin re = 3000; im = -4000; end
                1: begin re = k; im = 0; end
                2: begin
                    if (k == 0)      begin re = -32768; im = -32768; end
                    else if (k == 1) begin re = 0;      im = 32767;  end
                    else if (k == 2) begin re = 32767;  im = -32768; end
                    else begin
                        re = int'($urandom_range(65535)) - 32768;
                        im = int'($urandom_range(65535)) - 32768;
                    end
                end
                3: begin re = 100; im = 0; end
                default: begin re = 7; im = 0; end
            endcase
            if (capture && k < N_BINS) exp_q.push_back(mag_model(re, im));
            drive_beat(re, im, k == last_beat);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc);
        int c;
        c = 0;
        while (!done && c < max_cyc) begin
            @(posedge clk); #1;
            c++;
        end
        n_vec++;
        if (done !== 1'b1) begin
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, c);
            n_err++;
        end
    endtask

    task automatic check_ram(input string name);
        int e;
        for (int k = 0; k < N_BINS; k++) begin
            rd_addr = 8'(k);
            @(posedge clk); #1;
            n_vec++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s bin %0d: scoreboard empty, rd_data=%0d", name, k, rd_data);
                n_err++;
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== 16'(e)) begin
                    $display("FAIL %s bin %0d: rd_data=%0d required %0d", name, k, rd_data, e);
                    n_err++;
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s leftover: %0d entries, required 0", name, exp_q.size());
            n_err++;
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_vec++;
        if ({done, busy, frame_err, s_tready} !== 4'b0000 || rd_data !== 16'd0) begin
            $display("FAIL reset: done/busy/err/rdy=%b rd_data=%0d required 0000/0",
                     {done, busy, frame_err, s_tready}, rd_data);
            n_err++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (s_tready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset_release: s_tready=%b busy=%b required 1/0", s_tready, busy);
            n_err++;
        end
    endtask

    task automatic test_const_frame();
        pulse_start();
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL start_busy: busy=%b required 1", busy);
            n_err++;
        end
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(0, 1'b1, FFT_LEN - 1);
        n_vec++;
        if (done !== 1'b0) begin
            $display("FAIL done_t0: done=%b required 0", done);
            n_err++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0) begin
            $display("FAIL done_t1: done=%b required 0", done);
            n_err++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL done_t2: done=%b busy=%b required 1/0", done, busy);
            n_err++;
        end
        check_ram("const");
    endtask

    task automatic test_ramp();
        pulse_start();
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(1, 1'b1, FFT_LEN - 1);
        wait_done(4);
        check_ram("ramp");
    endtask

    task automatic test_abs_edges();
        pulse_start();
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(2, 1'b1, FFT_LEN - 1);
        wait_done(4);
        check_ram("abs_edges");
    endtask

    task automatic test_frame_err();
        pulse_start();
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(0, 1'b0, 300);
        @(posedge clk); #1;
        n_vec++;
        if (frame_err !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL short_frame: err/done/busy=%b required 101", {frame_err, done, busy});
            n_err++;
        end
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(2, 1'b1, FFT_LEN - 1);
        wait_done(4);
        n_vec++;
        if (frame_err !== 1'b1) begin
            $display("FAIL err_sticky: frame_err=%b required 1", frame_err);
            n_err++;
        end
        check_ram("after_err");
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b1) begin
            $display("FAIL restart_e1: done=%b required 1", done);
            n_err++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL restart_e2: done/err/busy=%b required 001", {done, frame_err, busy});
            n_err++;
        end
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(3, 1'b1, FFT_LEN - 1);
        wait_done(4);
        check_ram("restart");
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_frame(0, 1'b0, FFT_LEN - 1);
        for (int k = 0; k < 120; k++) drive_beat(7, 0, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b0) begin
            $display("FAIL mid_reset: done/busy/rdy=%b required 000", {done, busy, s_tready});
            n_err++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(0, 1'b0, FFT_LEN - 1);
        send_frame(3, 1'b0, FFT_LEN - 1);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL ignore_beats: done/busy=%b required 00", {done, busy});
            n_err++;
        end
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(100);
        for (int i = 0; i < 3; i++) begin
            int e;
            rd_addr = (i == 0) ? 8'd0 : (i == 1) ? 8'd117 : 8'd200;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_vec++;
            if (rd_data !== 16'(e)) begin
                $display("FAIL partial_ram addr %0d: rd_data=%0d required %0d", rd_addr, rd_data, e);
                n_err++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_frame();
        test_ramp();
        test_abs_edges();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
